// File: rtl/fifo_stream_adapter_if.sv
// Handshake bundle between the async-FIFO read port, the adapter and the downstream stream.
// The master modport is the adapter side; the slave modport is the FIFO/stream environment side.
interface fifo_stream_adapter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       occ;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        input  fifo_empty, fifo_rd_data, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, occ, beat_cnt
    );

    modport slave (
        output fifo_empty, fifo_rd_data, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, occ, beat_cnt
    );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Turns a pop/empty async-FIFO read port into a valid/ready stream through a 3-entry skid buffer.
// Latency: m_valid two rd_clk edges after fifo_empty falls, then 1 beat/cycle.
// Backpressure: m_ready low holds m_data; pops stop once three words are stored or in flight.
module fifo_stream_adapter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    fifo_stream_adapter_if.master bus
);
    logic [WIDTH-1:0] mem [3];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [1:0]       stored;
    logic             rd_pend;
    logic             rst_done;
    logic             wr;
    logic             acc;
    logic [1:0]       stored_nxt;
    logic             rd_pend_nxt;

    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // rst_done keeps the first pop off until the first edge after reset release.
    assign bus.fifo_rd_en = rst_done && !bus.fifo_empty && !bus.flush &&
                            (({1'b0, stored} + {2'b00, rd_pend}) < 3'd3);
    assign wr          = rd_pend && !bus.flush;
    assign acc         = bus.m_valid && bus.m_ready && !bus.flush;
    assign bus.m_valid = (stored != 2'd0);
    assign bus.m_data  = mem[head];

    always_comb begin
        stored_nxt  = stored;
        rd_pend_nxt = bus.fifo_rd_en;
        if (bus.flush) begin
            stored_nxt = 2'd0;
        end else begin
            case ({wr, acc})
                2'b10:   stored_nxt = stored + 2'd1;
                2'b01:   stored_nxt = stored - 2'd1;
                default: stored_nxt = stored;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            head         <= 2'd0;
            tail         <= 2'd0;
            stored       <= 2'd0;
            rd_pend      <= 1'b0;
            rst_done     <= 1'b0;
            bus.occ      <= 2'd0;
            bus.beat_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rst_done <= 1'b1;
            stored   <= stored_nxt;
            rd_pend  <= rd_pend_nxt;
            bus.occ  <= stored_nxt + {1'b0, rd_pend_nxt};
            if (bus.flush) begin
                head <= 2'd0;
                tail <= 2'd0;
            end else begin
                if (wr) begin
                    mem[tail] <= bus.fifo_rd_data;
                    tail      <= inc3(tail);
                end
                if (acc) begin
                    head         <= inc3(head);
                    bus.beat_cnt <= bus.beat_cnt + 1'b1;
                end
            end
        end
    end

    wr_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(wr && stored == 2'd3));
endmodule
